// File: rtl/program_run_ctrl_pkg.sv
// Shared definitions for the program load/run controller: command bytes,
// FSM state encoding and the load-terminating instruction word.
package program_run_ctrl_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_NEXT = 8'h4E;
    localparam logic [7:0] CMD_END  = 8'h45;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RUN_CONT = 3'd2,
        ST_RUN_STEP = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/program_run_ctrl_word_assembler.sv
// Packs a stream of bytes MSB-first into words; word_ready pulses for one
// cycle, the cycle after the byte that completes a word.
module program_run_ctrl_word_assembler #(
    parameter int N_BITS = 32,
    parameter int N_BYTE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [N_BYTE-1:0] i_byte,
    input  logic              i_strobe,
    output logic [N_BITS-1:0] o_word,
    output logic              o_word_ready
);

    localparam int BYTES_PER_WORD = N_BITS / N_BYTE;
    localparam int CNT_BITS       = $clog2(BYTES_PER_WORD);

    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [N_BITS-1:0]   word_q, word_d;
    logic                ready_q, ready_d;

    always_comb begin
        cnt_d   = cnt_q;
        word_d  = word_q;
        ready_d = 1'b0;
        if (clear) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (i_strobe) begin
            word_d = {word_q[N_BITS-N_BYTE-1:0], i_byte};
            if (cnt_q == CNT_BITS'(BYTES_PER_WORD - 1)) begin
                ready_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            word_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            ready_q <= ready_d;
        end
    end

    assign o_word       = word_q;
    assign o_word_ready = ready_q;

endmodule

// File: rtl/program_run_ctrl.sv
// Debug-side sequencer: loads instruction memory from UART bytes, then
// gates the fetch/pipeline valid in continuous or single-step mode.
module program_run_ctrl
    import program_run_ctrl_pkg::*;
#(
    parameter int N_BITS    = 32,
    parameter int N_BYTE    = 8,
    parameter int MEM_DEPTH = 2048,
    parameter int ADDR_BITS = 11
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [N_BYTE-1:0]    i_rx_data,
    input  logic                 i_rx_done,
    input  logic                 i_pipeline_halt,
    output logic                 o_mem_wr_en,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic [N_BITS-1:0]    o_mem_data,
    output logic                 o_valid,
    output logic                 o_pipe_reset,
    output logic                 o_loaded,
    output logic                 o_load_overflow,
    output logic                 o_done,
    output logic [2:0]           o_state
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(MEM_DEPTH - 1);

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   loaded_q, loaded_d;
    logic                   ovf_q, ovf_d;
    logic                   valid_q, valid_d;
    logic                   prst_q, prst_d;
    logic                   done_q, done_d;
    logic                   asm_clear;
    logic                   asm_strobe;
    logic [N_BITS-1:0]      asm_word;
    logic                   asm_ready;

    assign asm_strobe = i_rx_done && (state_q == ST_LOAD);

    program_run_ctrl_word_assembler #(
        .N_BITS (N_BITS),
        .N_BYTE (N_BYTE)
    ) u_asm (
        .clk          (i_clock),
        .rst          (i_reset),
        .clear        (asm_clear),
        .i_byte       (i_rx_data),
        .i_strobe     (asm_strobe),
        .o_word       (asm_word),
        .o_word_ready (asm_ready)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        loaded_d  = loaded_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        prst_d    = 1'b0;
        asm_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_rx_done) begin
                    if (i_rx_data == CMD_LOAD) begin
                        state_d   = ST_LOAD;
                        loaded_d  = 1'b0;
                        ovf_d     = 1'b0;
                        addr_d    = '0;
                        asm_clear = 1'b1;
                    end else if (loaded_q && (i_rx_data == CMD_CONT)) begin
                        state_d = ST_RUN_CONT;
                        prst_d  = 1'b1;
                    end else if (loaded_q && (i_rx_data == CMD_STEP)) begin
                        state_d = ST_RUN_STEP;
                        prst_d  = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                // asm_ready is the write cycle; decide the outcome as it retires
                if (asm_ready) begin
                    if (asm_word == HALT_WORD) begin
                        state_d  = ST_IDLE;
                        loaded_d = 1'b1;
                    end else if (addr_q == LAST_ADDR) begin
                        state_d  = ST_IDLE;
                        loaded_d = 1'b1;
                        ovf_d    = 1'b1;
                    end
                    if (addr_q != LAST_ADDR) begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_RUN_CONT: begin
                // halt may still be asserted from the previous run while the
                // pipeline is being reset, so it is ignored in that cycle
                if (!prst_q && i_pipeline_halt) begin
                    state_d = ST_DONE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            ST_RUN_STEP: begin
                if (!prst_q && i_pipeline_halt) begin
                    state_d = ST_DONE;
                end else if (i_rx_done && (i_rx_data == CMD_END)) begin
                    state_d = ST_DONE;
                end else if (i_rx_done && (i_rx_data == CMD_NEXT)) begin
                    valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_LOAD) begin
            prst_d = 1'b1;
        end
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            loaded_q <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            prst_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            loaded_q <= loaded_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            prst_q   <= prst_d;
            done_q   <= done_d;
        end
    end

    assign o_mem_wr_en     = asm_ready;
    assign o_mem_addr      = addr_q;
    assign o_mem_data      = asm_word;
    assign o_valid         = valid_q;
    assign o_pipe_reset    = prst_q;
    assign o_loaded        = loaded_q;
    assign o_load_overflow = ovf_q;
    assign o_done          = done_q;
    assign o_state         = state_q;

endmodule

// File: tb/tb_program_run_ctrl.sv
// Bench for program_run_ctrl: behavioural model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_program_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        halt = 1'b0;

    logic        o_mem_wr_en;
    logic [10:0] o_mem_addr;
    logic [31:0] o_mem_data;
    logic        o_valid;
    logic        o_pipe_reset;
    logic        o_loaded;
    logic        o_load_overflow;
    logic        o_done;
    logic [2:0]  o_state;

    program_run_ctrl dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_rx_data       (rx_data),
        .i_rx_done       (rx_done),
        .i_pipeline_halt (halt),
        .o_mem_wr_en     (o_mem_wr_en),
        .o_mem_addr      (o_mem_addr),
        .o_mem_data      (o_mem_data),
        .o_valid         (o_valid),
        .o_pipe_reset    (o_pipe_reset),
        .o_loaded        (o_loaded),
        .o_load_overflow (o_load_overflow),
        .o_done          (o_done),
        .o_state         (o_state)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int          ms = 0;
    bit          live = 0;
    bit          e_rst = 0, e_wr = 0, e_valid = 0, e_prst = 0, e_done = 0;
    bit          m_loaded = 0, m_ovf = 0, fresh = 0, wpend = 0;
    bit          nv, nd, np, nw;
    logic [31:0] ma = 0, e_waddr = 0, wword = 0;
    logic [7:0]  mq[$];

    initial forever begin
        @(posedge clk);
        live = 1;
        if (rst) begin
            ms = 0; e_rst = 1; e_wr = 0; e_valid = 0; e_prst = 0; e_done = 0;
            m_loaded = 0; m_ovf = 0; fresh = 0; wpend = 0; ma = 0;
            mq.delete();
        end else begin
            nv = 0; nd = 0; np = 0; nw = 0;
            case (ms)
                0: if (rx_done) begin
                    if (rx_data == 8'h4C) begin
                        ms = 1; m_loaded = 0; m_ovf = 0; ma = 0; wpend = 0; np = 1;
                        mq.delete();
                    end else if (m_loaded && (rx_data == 8'h43 || rx_data == 8'h53)) begin
                        ms = (rx_data == 8'h43) ? 2 : 3; np = 1; fresh = 1;
                    end
                end
                1: begin
                    np = 1;
                    if (wpend) begin
                        wpend = 0;
                        if (wword == 32'hFFFF_FFFF) begin
                            ms = 0; m_loaded = 1; np = 0;
                        end else if (ma == 2047) begin
                            ms = 0; m_loaded = 1; m_ovf = 1; np = 0;
                        end
                        if (ma != 2047) ma = ma + 1;
                    end
                    if (rx_done) begin
                        mq.push_back(rx_data);
                        if (mq.size() == 4) begin
                            wword = {mq[0], mq[1], mq[2], mq[3]};
                            mq.delete();
                            wpend = 1; nw = 1; e_waddr = ma;
                        end
                    end
                end
                2: begin
                    if (fresh) begin fresh = 0; nv = 1; end
                    else if (halt) begin ms = 4; nd = 1; end
                    else nv = 1;
                end
                3: begin
                    if (!fresh && halt) begin ms = 4; nd = 1; end
                    else if (rx_done && rx_data == 8'h45) begin ms = 4; nd = 1; end
                    else if (rx_done && rx_data == 8'h4E) nv = 1;
                    fresh = 0;
                end
                default: ms = 0;
            endcase
            e_rst = 0; e_valid = nv; e_done = nd; e_prst = np; e_wr = nw;
        end
    end

    // ---------------- compare + monitor ----------------
    int          valid_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    initial forever begin
        @(negedge clk);
        if (live) begin
            check("state",     32'(o_state),         32'(ms));
            check("valid",     32'(o_valid),         32'(e_valid));
            check("wr_en",     32'(o_mem_wr_en),     32'(e_wr));
            check("pipe_rst",  32'(o_pipe_reset),    32'(e_prst));
            check("done",      32'(o_done),          32'(e_done));
            check("loaded",    32'(o_loaded),        32'(m_loaded));
            check("overflow",  32'(o_load_overflow), 32'(m_ovf));
            if (e_wr) begin
                check("wr_addr", 32'(o_mem_addr), e_waddr);
                check("wr_data", o_mem_data,      wword);
            end
            if (e_rst) begin
                check("rst_addr", 32'(o_mem_addr), 32'h0);
                check("rst_data", o_mem_data,      32'h0);
            end
        end
        if (o_valid) valid_cnt++;
        if (o_done) done_cnt++;
        if (o_mem_wr_en) begin
            wa.push_back(32'(o_mem_addr));
            wd.push_back(o_mem_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0;
        tick(gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send(w[31:24], gap);
        send(w[23:16], gap);
        send(w[15:8],  gap);
        send(w[7:0],   gap);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (done_cnt == 0 && k < 50) begin
            tick(1);
            k++;
        end
        check(name, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        logic [31:0] w;
        tick(3);
        rst = 1'b0;
        check("reset_state", 32'(o_state), 32'd0);
        check("reset_outs", {22'd0, o_mem_wr_en, o_valid, o_pipe_reset, o_loaded,
                             o_load_overflow, o_done, 1'b0, o_state}, 32'd0);
        tick(2);

        // continuous run before any program is loaded is ignored
        send(8'h43, 3);
        check("cont_unloaded_state", 32'(o_state), 32'd0);
        check("cont_unloaded_prst",  32'(o_pipe_reset), 32'd0);

        // reset in the middle of a load
        wa.delete(); wd.delete();
        send(8'h4C, 1);
        send_word(32'h1122_3344, 1);
        send(8'h55, 1);
        send(8'h66, 1);
        check("midload_state", 32'(o_state), 32'd1);
        rst = 1'b1;
        tick(1);
        check("midrst_state", 32'(o_state), 32'd0);
        check("midrst_outs", {22'd0, o_mem_wr_en, o_valid, o_pipe_reset, o_loaded,
                              o_load_overflow, o_done, 1'b0, o_state}, 32'd0);
        check("midrst_addr", 32'(o_mem_addr), 32'd0);
        check("midrst_data", o_mem_data, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        wa.delete(); wd.delete();
        send(8'h4C, 1);
        send_word(32'hAABB_CCDD, 1);
        tick(2);
        check("reload_count", 32'(wa.size()), 32'd1);
        if (wa.size() >= 1) begin
            check("reload_addr", wa[0], 32'd0);
            check("reload_data", wd[0], 32'hAABB_CCDD);
        end
        send_word(32'hFFFF_FFFF, 1);
        tick(3);

        // normal load: one instruction plus halt word
        wa.delete(); wd.delete();
        send(8'h4C, 2);
        send_word(32'h2001_0005, 2);
        send_word(32'hFFFF_FFFF, 0);
        tick(4);
        check("load_count", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check("load_a0", wa[0], 32'd0);
            check("load_d0", wd[0], 32'h2001_0005);
            check("load_a1", wa[1], 32'd1);
            check("load_d1", wd[1], 32'hFFFF_FFFF);
        end
        check("load_loaded", 32'(o_loaded), 32'd1);
        check("load_ovf",    32'(o_load_overflow), 32'd0);
        check("load_state",  32'(o_state), 32'd0);

        // continuous run, halt raised on the 10th cycle after the command
        valid_cnt = 0; done_cnt = 0;
        send(8'h43, 0);
        check("cont_prst", 32'(o_pipe_reset), 32'd1);
        tick(9);
        halt = 1'b1;
        wait_done("cont_done");
        halt = 1'b0;
        check("cont_valid_cycles", 32'(valid_cnt), 32'd9);
        tick(2);
        check("cont_end_state", 32'(o_state), 32'd0);
        check("cont_loaded", 32'(o_loaded), 32'd1);

        // single-step: three N pulses then E
        valid_cnt = 0; done_cnt = 0;
        send(8'h53, 3);
        send(8'h4E, 3);
        send(8'h99, 2);
        send(8'h4E, 3);
        send(8'h4E, 3);
        send(8'h45, 0);
        wait_done("step_done");
        check("step_valid_pulses", 32'(valid_cnt), 32'd3);
        tick(2);
        check("step_end_state", 32'(o_state), 32'd0);

        // N coincident with halt: halt wins
        valid_cnt = 0; done_cnt = 0;
        send(8'h53, 3);
        halt = 1'b1;
        send(8'h4E, 0);
        halt = 1'b0;
        wait_done("stephalt_done");
        check("stephalt_valid", 32'(valid_cnt), 32'd0);
        tick(2);

        // fill all of memory with non-halt words
        wa.delete(); wd.delete();
        send(8'h4C, 0);
        for (int i = 0; i < 2048; i++) begin
            w = 32'(i);
            send_word(w, 0);
        end
        tick(4);
        check("ovf_count", 32'(wa.size()), 32'd2048);
        if (wa.size() == 2048) begin
            check("ovf_last_addr", wa[2047], 32'd2047);
            check("ovf_last_data", wd[2047], 32'd2047);
        end
        check("ovf_flag",   32'(o_load_overflow), 32'd1);
        check("ovf_loaded", 32'(o_loaded), 32'd1);
        check("ovf_state",  32'(o_state), 32'd0);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/program_run_ctrl.md
Name: program_run_ctrl

Overview:
- Debug-side controller that sequences the instruction-fetch datapath.
- It loads the program into instruction memory from a UART byte stream, then drives the fetch and pipeline `valid` enable in continuous or single-step mode until the pipeline reports halt.
- It sits between the UART receiver and the fetch stage and program memory.
- It is the only source of the fetch stage's `valid` input and of the memory write port.

Parameters:
- N_BITS, 32, instruction/data word width.
- N_BYTE, 8, UART byte width.
- MEM_DEPTH, 2048, instruction memory depth in words.
- ADDR_BITS, 11, memory word-address width (log2 MEM_DEPTH).
- HALT_WORD, 32'hFFFF_FFFF, instruction word that terminates a load.

Ports:
- i_clock  in  1  system clock, all logic on posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  N_BYTE  received UART byte, valid when i_rx_done=1.
- i_rx_done  in  1  one-cycle strobe per received byte.
- i_pipeline_halt  in  1  pipeline has retired the halt instruction (level).
- o_mem_wr_en  out  1  instruction memory write strobe.
- o_mem_addr  out  ADDR_BITS  write word address.
- o_mem_data  out  N_BITS  write data.
- o_valid  out  1  advance enable to the fetch stage and pipeline.
- o_pipe_reset  out  1  reset to the pipeline (restarts PC at 0).
- o_loaded  out  1  a program is resident.
- o_load_overflow  out  1  the last load filled memory without seeing HALT_WORD.
- o_done  out  1  one-cycle pulse when a run ends.
- o_state  out  3  current FSM state, for debug.

Behaviour:
- Clock and reset:
  - Single clock i_clock; reset i_reset is synchronous, active-high.
  - On reset, every output is 0, the state is IDLE, and the byte and word counters are 0.
  - Reset in any state aborts the operation and takes effect at the same edge.
- All outputs are registered.
- Command bytes: 'L'=8'h4C load, 'C'=8'h43 continuous, 'S'=8'h53 step, 'N'=8'h4E next, 'E'=8'h45 end step.
  - Unrecognised bytes are ignored in every state.
- States: IDLE=0, LOAD=1, RUN_CONT=2, RUN_STEP=3, DONE=4.
- IDLE:
  - 'L' → LOAD. Clears o_loaded, o_load_overflow, the byte counter and the address counter.
  - 'C' or 'S' with o_loaded=1 → RUN_CONT or RUN_STEP. o_pipe_reset pulses high for exactly the next cycle.
  - 'C' or 'S' with o_loaded=0 is ignored.
- LOAD:
  - o_pipe_reset is held at 1 for the whole state.
  - Bytes are assembled MSB-first: word = {word[23:0], byte}.
  - On the 4th byte, o_mem_wr_en=1 for one cycle on the next cycle, with o_mem_addr equal to the current address and o_mem_data equal to the assembled word. The address then increments.
  - Written word == HALT_WORD → IDLE, o_loaded=1. The halt word is stored.
  - Write to address MEM_DEPTH-1 that is not HALT_WORD → IDLE, o_loaded=1, o_load_overflow=1. There is no address wrap.
  - In LOAD, all bytes are data; command codes are not decoded.
- RUN_CONT:
  - o_valid=1 starting the cycle after o_pipe_reset.
  - At the first edge with i_pipeline_halt=1, o_valid=0 on the next cycle → DONE.
  - Received bytes are ignored.
- RUN_STEP:
  - o_valid is 0 by default.
  - Each 'N' produces o_valid=1 for exactly one cycle, the cycle after i_rx_done.
  - 'E' → DONE.
  - i_pipeline_halt=1 → DONE.
  - If halt and an 'N' strobe occur in the same cycle, halt wins and no pulse is produced.
- DONE:
  - o_done=1 for one cycle, then IDLE.
  - The pipeline is not reset, so its state stays readable.
  - o_loaded stays 1, so the program can be rerun without reloading.
- o_mem_wr_en is never high outside LOAD.
- o_valid is never high outside RUN_CONT and RUN_STEP.

Decomposition:
- Shared package holds:
  - the command byte constants (CMD_LOAD, CMD_CONT, CMD_STEP, CMD_NEXT, CMD_END);
  - the state encoding localparams;
  - HALT_WORD.
- One natural sub-module, word_assembler:
  - inputs: byte and strobe;
  - outputs: 32-bit word and one-cycle word_ready;
  - has a clear input.

Test Plan:
- Reset mid-LOAD after 6 bytes → all outputs 0, state IDLE. A new 'L' plus 4 bytes writes addr 0.
- 'L', then bytes 20 01 00 05, then FF FF FF FF → writes 0x20010005 @0, then 0xFFFFFFFF @1. o_loaded=1, state IDLE, o_load_overflow=0.
- After load, 'C' → o_pipe_reset pulse for 1 cycle, then o_valid=1. Raise i_pipeline_halt at cycle 10 → o_valid=0 next cycle, o_done one-cycle pulse, state IDLE.
- After load, 'S', then 3×'N' → exactly 3 single-cycle o_valid pulses. 'E' → o_done, IDLE.
- In RUN_STEP, 'N' strobe coincident with i_pipeline_halt → no o_valid pulse, DONE.
- 'C' before any load → ignored, state stays IDLE. Load of 2048 non-halt words → o_load_overflow=1, last write at addr 2047.
